// File: rtl/prefetch_queue.sv
// prefetch_queue: byte-wide instruction prefetch FIFO for an 8088-class core.
// Fetches code bytes from cs:fetch_ip into a QDEPTH-byte queue and presents
// the head byte with its IP to the decoder; flush reloads cs:ip and empties.
// Optional macro PREFETCH_BYPASS_EN: an empty queue forwards the byte being
// fetched straight to q_data in the same cycle.
// Ports:
//   clock, resetn        : clock, async active-low reset
//   locked               : global enable; 0 freezes all state
//   flush, new_cs, new_ip: reload segment/offset and discard queue
//   mem_grant, mem_bus   : bus free this cycle, combinational read data
//   mem_address, mem_rd  : fetch address and fetch strobe
//   q_data, q_valid,
//   q_pop, q_ip, q_cs,
//   q_count              : head byte interface and occupancy
module prefetch_queue #(
    parameter int          QDEPTH   = 4,
    parameter int          ADDR_W   = 20,
    parameter logic [15:0] RESET_CS = 16'hF000,
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    locked,
    input  logic                    flush,
    input  logic [15:0]             new_cs,
    input  logic [15:0]             new_ip,
    input  logic                    mem_grant,
    input  logic [7:0]              mem_bus,
    output logic [ADDR_W-1:0]       mem_address,
    output logic                    mem_rd,
    output logic [7:0]              q_data,
    output logic                    q_valid,
    input  logic                    q_pop,
    output logic [15:0]             q_ip,
    output logic [15:0]             q_cs,
    output logic [$clog2(QDEPTH):0] q_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [15:0]       cs;
    logic [15:0]       fetch_ip;
    logic [15:0]       head_ip;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [7:0]        qbuf [QDEPTH];

    logic [ADDR_W-1:0] seg_base;
    logic [ADDR_W-1:0] seg_off;
    logic              not_empty;
    logic              store;
    logic              pop_q;
    logic              direct;

    // Segment base and offset are summed at ADDR_W so the address wraps
    // naturally at the top of physical memory.
    assign seg_base    = ADDR_W'({cs, 4'h0});
    assign seg_off     = ADDR_W'(fetch_ip);
    assign mem_address = seg_base + seg_off;

    assign not_empty = (count != '0);

    // Fullness uses the registered count: a full queue never fetches,
    // even in a cycle where the head is popped.
    assign mem_rd = locked & resetn & mem_grant & ~flush & (count < FULL);

    assign pop_q = locked & ~flush & q_pop & not_empty;

`ifdef PREFETCH_BYPASS_EN
    logic byp;

    // When empty, the byte on the bus is shown to the decoder directly;
    // if the decoder takes it, it never enters the queue.
    assign byp     = mem_rd & ~not_empty;
    assign direct  = byp & q_pop;
    assign q_valid = not_empty | byp;
    assign q_data  = byp ? mem_bus : qbuf[head];
`else
    assign direct  = 1'b0;
    assign q_valid = not_empty;
    assign q_data  = qbuf[head];
`endif

    assign store = mem_rd & ~direct;

    assign q_ip    = head_ip;
    assign q_cs    = cs;
    assign q_count = count;

    always_ff @(posedge clock) begin
        if (store) begin
            qbuf[tail] <= mem_bus;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cs       <= RESET_CS;
            fetch_ip <= RESET_IP;
            head_ip  <= RESET_IP;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (locked) begin
            if (flush) begin
                cs       <= new_cs;
                fetch_ip <= new_ip;
                head_ip  <= new_ip;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (mem_rd) begin
                    fetch_ip <= fetch_ip + 16'd1;
                end
                if (store) begin
                    tail <= tail + PW'(1);
                end
                if (pop_q) begin
                    head <= head + PW'(1);
                end
                if (pop_q | direct) begin
                    head_ip <= head_ip + 16'd1;
                end
                unique case ({store, pop_q})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed self-checking bench for prefetch_queue.
// Drives inputs after each rising edge and samples outputs #1 later.
module tb_prefetch_queue;

    logic        clock;
    logic        resetn;
    logic        locked;
    logic        flush;
    logic [15:0] new_cs;
    logic [15:0] new_ip;
    logic        mem_grant;
    logic [7:0]  mem_bus;
    logic [19:0] mem_address;
    logic        mem_rd;
    logic [7:0]  q_data;
    logic        q_valid;
    logic        q_pop;
    logic [15:0] q_ip;
    logic [15:0] q_cs;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;
    int nfetch;

    prefetch_queue #(
        .QDEPTH(4),
        .ADDR_W(20),
        .RESET_CS(16'hF000),
        .RESET_IP(16'h0000)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .locked(locked),
        .flush(flush),
        .new_cs(new_cs),
        .new_ip(new_ip),
        .mem_grant(mem_grant),
        .mem_bus(mem_bus),
        .mem_address(mem_address),
        .mem_rd(mem_rd),
        .q_data(q_data),
        .q_valid(q_valid),
        .q_pop(q_pop),
        .q_ip(q_ip),
        .q_cs(q_cs),
        .q_count(q_count)
    );

    function automatic logic [7:0] rom(input logic [19:0] a);
        case (a)
            20'hF0000: rom = 8'h90;
            20'hF0001: rom = 8'hB8;
            20'hF0002: rom = 8'h34;
            20'hF0003: rom = 8'h12;
            20'hF0004: rom = 8'h56;
            20'h00100: rom = 8'hC3;
            default:   rom = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    assign mem_bus = rom(mem_address);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn    = 1'b0;
        locked    = 1'b1;
        flush     = 1'b0;
        new_cs    = 16'h0;
        new_ip    = 16'h0;
        mem_grant = 1'b1;
        q_pop     = 1'b0;
        #12;
        check("rst_count", 32'(q_count), 32'd0);
        check("rst_valid", 32'(q_valid), 32'd0);
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_addr", 32'(mem_address), 32'hF0000);
        check("rst_cs", 32'(q_cs), 32'hF000);
        check("rst_ip", 32'(q_ip), 32'h0000);
        tick();
        resetn = 1'b1;
        #1;

        // Fill the queue from F0000
        for (int i = 0; i < 4; i++) begin
            check("fill_rd", 32'(mem_rd), 32'd1);
            check("fill_addr", 32'(mem_address), 32'hF0000 + 32'(i));
            tick();
        end
        check("full_count", 32'(q_count), 32'd4);
        check("full_rd", 32'(mem_rd), 32'd0);
        check("full_data", 32'(q_data), 32'h90);
        check("full_ip", 32'(q_ip), 32'h0000);
        check("full_valid", 32'(q_valid), 32'd1);

        // Pop twice from a full queue
        q_pop = 1'b1;
        #1;
        check("pop1_data", 32'(q_data), 32'h90);
        check("pop1_rd", 32'(mem_rd), 32'd0);
        tick();
        check("pop2_data", 32'(q_data), 32'hB8);
        check("pop2_rd", 32'(mem_rd), 32'd1);
        check("pop2_addr", 32'(mem_address), 32'hF0004);
        tick();
        q_pop = 1'b0;
        #1;
        check("pop_ip", 32'(q_ip), 32'h0002);
        check("pop_count", 32'(q_count), 32'd3);
        check("pop_data", 32'(q_data), 32'h34);

        // Flush to 1234:FFFE, fetch across the offset wrap
        flush  = 1'b1;
        new_cs = 16'h1234;
        new_ip = 16'hFFFE;
        #1;
        check("fl_rd", 32'(mem_rd), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_count", 32'(q_count), 32'd0);
        check("fl_valid", 32'(q_valid), 32'd0);
        check("fl_cs", 32'(q_cs), 32'h1234);
        check("fl_ip", 32'(q_ip), 32'hFFFE);
        check("wr_a0", 32'(mem_address), 32'h2233E);
        check("wr_rd0", 32'(mem_rd), 32'd1);
        tick();
        check("wr_valid", 32'(q_valid), 32'd1);
        check("wr_a1", 32'(mem_address), 32'h2233F);
        tick();
        check("wr_a2", 32'(mem_address), 32'h12340);
        tick();
        check("wr_count", 32'(q_count), 32'd3);
        check("wr_data", 32'(q_data), 32'(rom(20'h2233E)));
        check("wr_ip", 32'(q_ip), 32'hFFFE);

        // Grant toggling with q_pop held high
        flush  = 1'b1;
        new_cs = 16'h0000;
        new_ip = 16'h0200;
        tick();
        flush  = 1'b0;
        q_pop  = 1'b1;
        nfetch = 0;
        for (int i = 0; i < 6; i++) begin
            mem_grant = (i < 4) && (i % 2 == 0);
            #1;
            if (mem_rd) nfetch++;
            if (i == 0) check("tg_v0", 32'(q_valid), 32'd0);
            if (i == 1) check("tg_d1", 32'(q_data), 32'(rom(20'h00200)));
            if (i == 2) check("tg_v2", 32'(q_valid), 32'd0);
            if (i == 3) check("tg_d3", 32'(q_data), 32'(rom(20'h00201)));
            tick();
        end
        check("tg_fetches", 32'(nfetch), 32'd2);
        check("tg_ip", 32'(q_ip), 32'h0202);
        check("tg_count", 32'(q_count), 32'd0);

        // Flush and pop together with three bytes queued
        q_pop     = 1'b0;
        mem_grant = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("fp_pre", 32'(q_count), 32'd3);
        flush  = 1'b1;
        q_pop  = 1'b1;
        new_cs = 16'h0040;
        new_ip = 16'h0010;
        #1;
        check("fp_rd", 32'(mem_rd), 32'd0);
        tick();
        flush = 1'b0;
        q_pop = 1'b0;
        #1;
        check("fp_count", 32'(q_count), 32'd0);
        check("fp_valid", 32'(q_valid), 32'd0);
        check("fp_ip", 32'(q_ip), 32'h0010);
        check("fp_addr", 32'(mem_address), 32'h00410);

        // locked=0 freezes everything
        tick();
        tick();
        check("lk_pre", 32'(q_count), 32'd2);
        locked = 1'b0;
        q_pop  = 1'b1;
        flush  = 1'b1;
        #1;
        check("lk_rd", 32'(mem_rd), 32'd0);
        tick();
        check("lk_count", 32'(q_count), 32'd2);
        check("lk_ip", 32'(q_ip), 32'h0010);
        check("lk_cs", 32'(q_cs), 32'h0040);
        locked = 1'b1;
        flush  = 1'b0;
        q_pop  = 1'b0;

`ifdef PREFETCH_BYPASS_EN
        flush  = 1'b1;
        new_cs = 16'h0000;
        new_ip = 16'h0100;
        tick();
        flush = 1'b0;
        q_pop = 1'b1;
        #1;
        check("by_valid", 32'(q_valid), 32'd1);
        check("by_data", 32'(q_data), 32'hC3);
        tick();
        q_pop     = 1'b0;
        mem_grant = 1'b0;
        #1;
        check("by_count", 32'(q_count), 32'd0);
        check("by_ip", 32'(q_ip), 32'h0101);
        mem_grant = 1'b1;
`endif

        // Asynchronous reset in mid-cycle
        #2;
        resetn = 1'b0;
        #1;
        check("ar_count", 32'(q_count), 32'd0);
        check("ar_cs", 32'(q_cs), 32'hF000);
        check("ar_rd", 32'(mem_rd), 32'd0);
        check("ar_addr", 32'(mem_address), 32'hF0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Parametrised byte-wide instruction prefetch unit; the next-generation front end for the 8088-class core.
- Fetches code bytes from CS:IP-linear memory into a FIFO of QDEPTH bytes whenever the bus is granted.
- Presents the head byte and its IP to the core's decoder.
- Flush reloads CS:IP on jumps and interrupts and discards queued bytes.

Parameters:
- QDEPTH, 4, queue depth in bytes; power of two, 2..16; 4 gives 8088 behaviour, 8 covers the 8086-style queue.
- ADDR_W, 20, physical address width; address = ({cs,4'h0} + fetch_ip) mod 2^ADDR_W.
- RESET_CS, 16'hF000, code segment after reset.
- RESET_IP, 16'h0000, instruction pointer after reset.

Ports:
- clock  in  1  system clock, all state on rising edge.
- resetn  in  1  reset; asynchronous assert, active-low.
- locked  in  1  global enable; when 0, all state holds and mem_rd is 0.
- flush  in  1  load new_cs:new_ip, empty the queue.
- new_cs  in  16  segment to load on flush.
- new_ip  in  16  offset to load on flush.
- mem_grant  in  1  bus free for code fetch this cycle (core data access has priority upstream).
- mem_bus  in  8  read data; valid in the same cycle as mem_address (combinational memory).
- mem_address  out  ADDR_W  fetch address, always driven from cs:fetch_ip.
- mem_rd  out  1  fetch performed this cycle.
- q_data  out  8  head byte.
- q_valid  out  1  head byte valid.
- q_pop  in  1  core consumes head byte this cycle.
- q_ip  out  16  IP of the head byte; equals architectural IP.
- q_cs  out  16  current code segment.
- q_count  out  $clog2(QDEPTH)+1  bytes held.

Behaviour:
- Reset (resetn=0, asynchronous):
  - cs=RESET_CS; fetch_ip=q_ip=RESET_IP.
  - count=0, q_valid=0, mem_rd=0, pointers=0.
  - mem_address=F0000 with default parameters.
  - Reset mid-fetch discards the byte; no partial state survives.
- Fetch (combinational mem_rd):
  - mem_rd = locked & resetn & mem_grant & ~flush & (count < QDEPTH).
  - On the clock edge with mem_rd=1: mem_bus written at the tail, tail++, fetch_ip++.
- Pop:
  - Effective when locked & ~flush & q_pop & q_valid: head++, q_ip++.
  - q_pop with q_valid=0 is ignored; no underflow.
- Simultaneous push and pop: count unchanged; both pointers advance.
  - Full is judged on registered count, so a full queue does not fetch even when popping that cycle.
- Empty queue with push: byte visible (q_valid=1) on the next cycle; no bypass unless the optional feature is enabled.
- Flush has priority over fetch and pop:
  - Next cycle: count=0, head=tail=0, cs=new_cs, fetch_ip=q_ip=new_ip.
  - No memory read occurs in the flush cycle.
- Wrap-around:
  - fetch_ip and q_ip wrap 16'hFFFF -> 16'h0000 within the segment.
  - Address addition wraps modulo 2^ADDR_W.
  - Queue pointers wrap modulo QDEPTH.
- Invariants:
  - fetch_ip - q_ip == count (mod 2^16) at all times.
  - q_data is undefined when q_valid=0.
- locked=0: no fetch, pop or flush; outputs reflect held state.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- With the macro defined:
  - When count==0 and mem_rd=1, q_valid=1 and q_data=mem_bus combinationally, with q_ip=fetch_ip.
  - If q_pop is also 1, the byte is consumed directly and not stored: count stays 0, fetch_ip++, q_ip++.
  - If q_pop is 0, the byte is stored normally.
- Without the macro: q_valid and q_data come from the registered queue only; first-byte latency after flush is 2 cycles.

Test Plan:
- Reset release, mem_grant=1, memory F0000..F0003 = 90,B8,34,12, q_pop=0:
  - mem_address steps F0000..F0003.
  - After 4 fetches q_count=4, mem_rd=0, q_data=90, q_ip=0000.
- Full queue with q_pop=1 for 2 cycles and mem_grant=1:
  - Pops return 90 then B8.
  - No fetch in the first pop cycle; fetch of F0004 in the next.
  - q_ip=0002 afterwards.
- Flush with new_cs=1234, new_ip=FFFE, mem_grant=1:
  - Next cycle q_count=0, q_valid=0.
  - Fetches at 2233E, 2233F, then 22340-FFFF wraps to offset 0000 (address 12340).
- mem_grant toggling 1,0,1,0 with q_pop=1 on every valid byte:
  - Exactly 2 bytes fetched and popped in order.
  - q_ip advances by 2; no q_pop is accepted while q_valid=0.
- Flush and q_pop asserted in the same cycle with count=3:
  - Pop ignored, queue empty.
  - q_ip=new_ip; mem_rd=0 in that cycle.
- With PREFETCH_BYPASS_EN, after flush to 0000:0100, mem_bus=C3, q_pop=1:
  - q_valid=1 and q_data=C3 in the same cycle.
  - Next cycle q_count=0, q_ip=0101.
